// File: rtl/sample_feeder_if.sv
// -----------------------------------------------------------------------------
// sample_feeder_if
//   Bundles the host-load bus and the controller sample bus of sample_feeder.
//
//   Parameters: WIDTH (signed sample field width), AW (address width).
//   Optional feature macro: FEEDER_EPOCH_CNT_EN (adds the 16-bit epoch signal).
//
//   Signals (direction seen from the feeder, i.e. the slave modport):
//     clr               in   synchronous dataset clear
//     wr_en             in   append one sample
//     wr_data           in   {t1, x2, x1}
//     full              out  dataset memory is full
//     count             out  number of stored samples
//     init_file_handler in   rewind to sample 0
//     next              in   advance to following sample
//     x1, x2, t1        out  current sample (registered)
//     EOF               out  last sample consumed
//     valid             out  x1/x2/t1 hold a real sample
//     epoch             out  completed passes (FEEDER_EPOCH_CNT_EN only)
// -----------------------------------------------------------------------------
interface sample_feeder_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 6
);
    logic                    clr;
    logic                    wr_en;
    logic [2*WIDTH:0]        wr_data;
    logic                    full;
    logic [AW:0]             count;
    logic                    init_file_handler;
    logic                    next;
    logic signed [WIDTH-1:0] x1;
    logic signed [WIDTH-1:0] x2;
    logic                    t1;
    logic                    EOF;
    logic                    valid;
`ifdef FEEDER_EPOCH_CNT_EN
    logic [15:0]             epoch;
`endif

    // Host / training-controller side.
    modport master (
        output clr, wr_en, wr_data, init_file_handler, next,
        input  full, count, x1, x2, t1, EOF, valid
`ifdef FEEDER_EPOCH_CNT_EN
        , input epoch
`endif
    );

    // Feeder side.
    modport slave (
        input  clr, wr_en, wr_data, init_file_handler, next,
        output full, count, x1, x2, t1, EOF, valid
`ifdef FEEDER_EPOCH_CNT_EN
        , output epoch
`endif
    );
endinterface

// File: rtl/sample_feeder.sv
// -----------------------------------------------------------------------------
// sample_feeder
//   Buffers a host-loaded dataset of (x1, x2, t1) samples and presents them one
//   at a time to the perceptron training controller. init_file_handler rewinds
//   to sample 0, next advances, EOF flags that the last sample was consumed.
//
//   Parameters: WIDTH (8), DEPTH (64), AW (6 = clog2(DEPTH)).
//   Optional feature macro: FEEDER_EPOCH_CNT_EN -- adds a 16-bit wrapping
//   pass counter (bus.epoch) bumped on every ACTIVE->END transition.
//
//   Ports:
//     clk   in  rising-edge clock
//     rst   in  asynchronous active-low reset
//     bus   sample_feeder_if.slave (load bus + sample bus, see interface)
// -----------------------------------------------------------------------------
module sample_feeder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic           clk,
    input  logic           rst,
    sample_feeder_if.slave bus
);
    localparam int              DW      = 2*WIDTH + 1;
    localparam logic [AW:0]     CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_END    = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [AW:0]     r_count;
    logic [AW-1:0]   r_ptr;
    logic [DW-1:0]   r_sample;
    logic            r_valid;

    logic            w_full;
    logic            w_wr;
    logic            w_last;
    logic            w_rewind;
    logic            w_first_load;
    logic            w_advance;
    logic            w_pass_done;
    logic            w_load;
    logic            w_eof;
    logic [AW-1:0]   w_rd_addr;

    assign w_full = (r_count == CNT_MAX);
    // A write coinciding with clr is dropped along with the dataset.
    assign w_wr   = bus.wr_en && !w_full && !bus.clr;
    // Compared against the live count so samples appended mid-pass are reached.
    assign w_last = (({1'b0, r_ptr} + CNT_ONE) == r_count);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        if (bus.clr) begin
            w_state_next = S_IDLE;
        end else if (w_rewind) begin
            w_state_next = w_first_load ? S_ACTIVE : S_END;
        end else if (w_pass_done) begin
            w_state_next = S_END;
        end
    end

    // ---------------- FSM: output / command decode ----------------
    // Priority is clr > init_file_handler > next; next only acts in ACTIVE.
    always_comb begin
        w_rewind     = 1'b0;
        w_first_load = 1'b0;
        w_advance    = 1'b0;
        w_pass_done  = 1'b0;
        if (!bus.clr) begin
            if (bus.init_file_handler) begin
                w_rewind     = 1'b1;
                w_first_load = (r_count != '0);
            end else if (bus.next && (r_state == S_ACTIVE)) begin
                w_pass_done  = w_last;
                w_advance    = !w_last;
            end
        end
        w_load    = w_first_load || w_advance;
        w_rd_addr = w_advance ? (r_ptr + AW'(1)) : '0;
        w_eof     = (r_state == S_END);
    end

    // ---------------- dataset memory (write port) ----------------
    // Reads only ever target addresses below count while the write goes to
    // count, so the two ports never collide.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_count[AW-1:0]] <= bus.wr_data;
        end
    end

    // ---------------- registered read into the sample outputs ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sample <= '0;
        end else if (bus.clr) begin
            r_sample <= '0;
        end else if (w_load) begin
            r_sample <= r_mem[w_rd_addr];
        end
    end

    // ---------------- count / pointer / valid ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_ptr   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (bus.clr) begin
                r_count <= '0;
            end else if (w_wr) begin
                r_count <= r_count + CNT_ONE;
            end

            if (bus.clr || w_rewind) begin
                r_ptr <= '0;
            end else if (w_advance) begin
                r_ptr <= r_ptr + AW'(1);
            end

            // valid holds through END; only clr drops it (rewind into an
            // empty dataset can only happen when valid is already low).
            if (bus.clr) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_valid <= 1'b1;
            end
        end
    end

`ifdef FEEDER_EPOCH_CNT_EN
    logic [15:0] r_epoch;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_epoch <= '0;
        end else if (bus.clr) begin
            r_epoch <= '0;
        end else if (w_pass_done) begin
            r_epoch <= r_epoch + 16'd1;
        end
    end

    assign bus.epoch = r_epoch;
`endif

    assign bus.full  = w_full;
    assign bus.count = r_count;
    assign bus.x1    = r_sample[WIDTH-1:0];
    assign bus.x2    = r_sample[2*WIDTH-1:WIDTH];
    assign bus.t1    = r_sample[2*WIDTH];
    assign bus.EOF   = w_eof;
    assign bus.valid = r_valid;

endmodule

// File: tb/tb_sample_feeder.sv
// -----------------------------------------------------------------------------
// tb_sample_feeder
//   Directed + randomized bench for sample_feeder. A dataset-level reference
//   model (queue of samples, read index, pass flags) predicts every output.
// -----------------------------------------------------------------------------
module tb_sample_feeder;
    localparam int WIDTH = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic clk;
    logic rst;

    sample_feeder_if #(.WIDTH(WIDTH), .AW(AW)) bus_if ();

    sample_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    logic [16:0] m_mem[$];
    int          m_ptr;
    logic [16:0] m_smp;
    bit          m_eof;
    bit          m_valid;
    bit          m_active;
    int          m_epoch;

    function automatic logic [16:0] mk(int x1, int x2, bit t);
        logic [7:0] a;
        logic [7:0] b;
        a = 8'(x1);
        b = 8'(x2);
        return {t, b, a};
    endfunction

    task automatic model_reset();
        m_mem.delete();
        m_ptr    = 0;
        m_smp    = '0;
        m_eof    = 0;
        m_valid  = 0;
        m_active = 0;
        m_epoch  = 0;
    endtask

    // One clock edge worth of dataset behaviour.
    task automatic model_edge(bit c, bit i, bit n, bit w, logic [16:0] d);
        int cnt;
        cnt = m_mem.size();
        if (c) begin
            model_reset();
            return;
        end
        if (i) begin
            m_ptr = 0;
            if (cnt > 0) begin
                m_active = 1;
                m_eof    = 0;
                m_valid  = 1;
                m_smp    = m_mem[0];
            end else begin
                m_active = 0;
                m_eof    = 1;
            end
        end else if (n && m_active) begin
            if (m_ptr < cnt - 1) begin
                m_ptr = m_ptr + 1;
                m_smp = m_mem[m_ptr];
            end else begin
                m_active = 0;
                m_eof    = 1;
                m_epoch  = (m_epoch + 1) % 65536;
            end
        end
        if (w && cnt < DEPTH) m_mem.push_back(d);
    endtask

    // ---------------- checking ----------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(bus_if.count), 32'(m_mem.size()));
        chk("full",  32'(bus_if.full),  32'(m_mem.size() == DEPTH));
        chk("x1",    32'($unsigned(bus_if.x1)), 32'(m_smp[7:0]));
        chk("x2",    32'($unsigned(bus_if.x2)), 32'(m_smp[15:8]));
        chk("t1",    32'(bus_if.t1),    32'(m_smp[16]));
        chk("EOF",   32'(bus_if.EOF),   32'(m_eof));
        chk("valid", 32'(bus_if.valid), 32'(m_valid));
`ifdef FEEDER_EPOCH_CNT_EN
        chk("epoch", 32'(bus_if.epoch), 32'(m_epoch));
`endif
    endtask

    // Drive one cycle of inputs, let the edge happen, then check at edge+1.
    task automatic cycle(bit c, bit i, bit n, bit w, logic [16:0] d);
        bus_if.clr               = c;
        bus_if.init_file_handler = i;
        bus_if.next              = n;
        bus_if.wr_en             = w;
        bus_if.wr_data           = d;
        @(posedge clk);
        model_edge(c, i, n, w, d);
        #1;
        check_all();
        $display("txn t=%0t clr=%0b init=%0b next=%0b wr=%0b data=%05h count=%0d x1=%0d x2=%0d t1=%0b eof=%0b valid=%0b",
                 $time, c, i, n, w, d, bus_if.count, bus_if.x1, bus_if.x2, bus_if.t1, bus_if.EOF, bus_if.valid);
    endtask

    task automatic load3();
        cycle(0, 0, 0, 1, mk(5, -3, 1));
        cycle(0, 0, 0, 1, mk(-2, 7, 0));
        cycle(0, 0, 0, 1, mk(1, 1, 1));
    endtask

    initial begin
        bus_if.clr               = 1'b0;
        bus_if.init_file_handler = 1'b0;
        bus_if.next              = 1'b0;
        bus_if.wr_en             = 1'b0;
        bus_if.wr_data           = '0;
        model_reset();

        // ---- reset ----
        rst = 1'b1;
        #3 rst = 1'b0;
        #1 check_all();
        repeat (2) @(posedge clk);
        #4 rst = 1'b1;
        #1 check_all();

        // ---- load three samples, first pass ----
        load3();
        chk("count_after_load", 32'(bus_if.count), 32'd3);
        cycle(0, 1, 0, 0, '0);
        chk("init_x1", 32'($unsigned(bus_if.x1)), 32'h05);
        chk("init_x2", 32'($unsigned(bus_if.x2)), 32'hFD);
        chk("init_t1", 32'(bus_if.t1), 32'd1);
        chk("init_valid", 32'(bus_if.valid), 32'd1);
        cycle(0, 0, 1, 0, '0);
        chk("step1_x1", 32'($unsigned(bus_if.x1)), 32'hFE);
        cycle(0, 0, 1, 0, '0);
        cycle(0, 0, 1, 0, '0);
        chk("pass_eof", 32'(bus_if.EOF), 32'd1);
        chk("pass_hold_x1", 32'($unsigned(bus_if.x1)), 32'h01);
        cycle(0, 0, 1, 0, '0);
`ifdef FEEDER_EPOCH_CNT_EN
        chk("epoch_one", 32'(bus_if.epoch), 32'd1);
`endif

        // ---- second pass ----
        cycle(0, 1, 0, 0, '0);
        chk("rewind_eof", 32'(bus_if.EOF), 32'd0);
        repeat (3) cycle(0, 0, 1, 0, '0);
`ifdef FEEDER_EPOCH_CNT_EN
        chk("epoch_two", 32'(bus_if.epoch), 32'd2);
`endif

        // ---- empty dataset rewind ----
        cycle(1, 0, 0, 0, '0);
        cycle(0, 1, 0, 0, '0);
        chk("empty_eof", 32'(bus_if.EOF), 32'd1);
        chk("empty_valid", 32'(bus_if.valid), 32'd0);

        // ---- fill to DEPTH, then overflow ----
        for (int k = 0; k < DEPTH; k++) cycle(0, 0, 0, 1, 17'($urandom));
        chk("full_set", 32'(bus_if.full), 32'd1);
        cycle(0, 0, 0, 1, 17'($urandom));
        chk("overflow_count", 32'(bus_if.count), 32'd64);
        cycle(0, 1, 0, 0, '0);
        repeat (5) cycle(0, 0, 1, 0, '0);

        // ---- clr beats everything in the same cycle ----
        cycle(1, 1, 1, 1, 17'h1ABCD);
        chk("clr_count", 32'(bus_if.count), 32'd0);
        chk("clr_x1", 32'($unsigned(bus_if.x1)), 32'd0);

        // ---- init beats next ----
        load3();
        cycle(0, 1, 0, 0, '0);
        cycle(0, 0, 1, 0, '0);
        cycle(0, 1, 1, 0, '0);
        chk("init_wins_x1", 32'($unsigned(bus_if.x1)), 32'h05);

        // ---- asynchronous reset mid-pass ----
        cycle(0, 0, 1, 0, '0);
        cycle(0, 0, 1, 0, '0);
        #2 rst = 1'b0;
        model_reset();
        #1 check_all();
        chk("async_valid", 32'(bus_if.valid), 32'd0);
        #2 rst = 1'b1;
        cycle(0, 1, 0, 0, '0);
        chk("post_reset_eof", 32'(bus_if.EOF), 32'd1);

        // ---- randomized traffic ----
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0,
                  17'($urandom));
        end

        bus_if.clr = 1'b0; bus_if.init_file_handler = 1'b0;
        bus_if.next = 1'b0; bus_if.wr_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sample_feeder.md
# sample_feeder

Training-sample source for the perceptron datapath, directly upstream of the training controller. It buffers a dataset of (x1, x2, t1) samples in an internal memory loaded by the host. It presents one sample at a time on registered outputs and advances on the controller's `next` pulse. It rewinds on `init_file_handler` and flags end-of-dataset on `EOF`, replacing a file handler in synthesizable form.

## Interface
- WIDTH, 8: signed width of x1/x2.
- DEPTH, 64: maximum number of stored samples.
- AW, 6: address width, equal to clog2(DEPTH).

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous dataset clear; count goes to 0.
- wr_en  in  1  append one sample at address `count`.
- wr_data  in  2*WIDTH+1  {t1, x2, x1}.
- full  out  1  count == DEPTH.
- count  out  AW+1  number of stored samples.
- init_file_handler  in  1  rewind to sample 0 (pulse).
- next  in  1  advance to the following sample (pulse).
- x1, x2  out  WIDTH  current sample, signed, registered.
- t1  out  1  current sample target bit, registered.
- EOF  out  1  last sample has been consumed.
- valid  out  1  x1/x2/t1 hold a real sample.
- epoch  out  16  completed passes; exists only with FEEDER_EPOCH_CNT_EN.

## Operation
- Storage: DEPTH × (2*WIDTH+1) memory, synchronous read and write. Write pointer equals `count`. Read pointer `ptr` is AW bits.
- Load:
  - `wr_en` && !full && !clr writes mem[count] and increments count.
  - A write while full is dropped; count is unchanged.
  - Writes are legal in any state. Appended samples become visible to the running pass because the EOF check uses the live count.
- FSM has three states: IDLE, ACTIVE, END.
- IDLE (after reset or clr): valid=0, EOF=0.
  - `init_file_handler`: if count>0, go to ACTIVE with ptr=0 and outputs loaded from mem[0]. If count==0, go to END with EOF=1.
  - `next` is ignored.
- ACTIVE: valid=1.
  - `next` with ptr<count-1: ptr increments and outputs load mem[ptr+1].
  - `next` with ptr==count-1: go to END, EOF=1, outputs hold their last values.
  - `init_file_handler` rewinds as described for IDLE.
- END: EOF=1, valid stays at its previous value.
  - `next` is ignored.
  - `init_file_handler` rewinds as described for IDLE and clears EOF.
- Priority: clr > init_file_handler > next.
  - clr forces IDLE, ptr=0, x1=x2=0, t1=0, EOF=0, valid=0.
  - A `wr_en` in the same cycle as clr is dropped.
- No arithmetic beyond the pointer/count increments. Sample fields pass through bit-exact with no sign change.

## Timing
- Reset (rst=0): state IDLE; count=0, ptr=0, x1=x2=0, t1=0, EOF=0, valid=0, full=0, epoch=0. Takes effect immediately, independent of clk.
- Reset mid-pass discards the dataset. The host must reload.
- `init_file_handler` sampled high at edge k: new sample and valid appear after edge k.
- `next` sampled high at edge k: new sample or EOF=1 appears after edge k. The controller issues `next` in one cycle and samples EOF in the following cycle, so EOF must be stable there.
- count/full update after the write edge.
- Multi-cycle `next` pulses advance once per cycle. The controller issues single-cycle pulses.

## Configuration
- FEEDER_EPOCH_CNT_EN defined:
  - `epoch` port exists.
  - It increments (16-bit, wrapping) on each ACTIVE→END transition.
  - clr or reset zeroes it.
- Not defined: no `epoch` port and no counter logic. All other behaviour is identical.

## Test plan
- Reset then load 3 samples {x1=5,x2=-3,t1=1}, {-2,7,0}, {1,1,1} → count=3, full=0. Pulse init → next cycle x1=5, x2=-3 (0xFD), t1=1, valid=1, EOF=0.
- From that state, pulse next three times → outputs step to (-2,7,0), then (1,1,1), then EOF=1 with outputs holding (1,1,1). A fourth next changes nothing. With the macro defined, epoch=1.
- After EOF, pulse init → EOF=0, outputs (5,-3,1) on the next cycle. A second full pass ends with epoch=2.
- count=0, pulse init → EOF=1, valid=0 on the next cycle. Write DEPTH=64 samples → full=1. The 65th write is dropped and count stays 64.
- Same cycle clr+init+next+wr_en → IDLE, count=0, all outputs zero. Same cycle init+next in ACTIVE at ptr=1 → ptr=0 (init wins).
- Assert rst low mid-pass (ptr=2) between clock edges → all outputs zero immediately. After release, init gives EOF=1 because count=0.
